// File: rtl/seq_sub32.sv
// ---------------------------------------------------------------------------
// seq_sub32 : multi-cycle W-bit subtractor, d = a - b - bin (mod 2^W)
//
// Works CHUNK bits per clock on operands latched at start, using the
// two's-complement identity a - b - bin = a + ~b + ~bin. The carry out of
// the last chunk is the inverted borrow.
//
// Parameters
//   W      operand / result width (default 32)
//   CHUNK  bits processed per RUN cycle; must divide W (1,2,4,8,16,32)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while busy=0 (IDLE or DONE)
//   a      in   minuend
//   b      in   subtrahend
//   bin    in   borrow-in
//   busy   out  high while chunks are being processed
//   done   out  one-cycle pulse when d/bout (and ovf) are valid
//   d      out  difference, held until the next start's first RUN update
//   ovf    out  signed overflow (only when SEQ_SUB32_OVF_EN is defined)
//   bout   out  borrow-out, 1 when unsigned a < b + bin
//
// Optional feature macro: SEQ_SUB32_OVF_EN (adds the ovf port and logic)
// ---------------------------------------------------------------------------
module seq_sub32 #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
`ifdef SEQ_SUB32_OVF_EN
    output logic         ovf,
`endif
    output logic         bout
);

    localparam int NCH = W / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r,  state_nxt_s;
    logic [CW-1:0]  cnt_r,    cnt_nxt_s;
    logic [W-1:0]   a_r,      a_nxt_s;
    logic [W-1:0]   b_r,      b_nxt_s;
    logic           carry_r,  carry_nxt_s;
    logic [W-1:0]   d_r,      d_nxt_s;
    logic           bout_r,   bout_nxt_s;
    logic           busy_r,   busy_nxt_s;
    logic           done_r,   done_nxt_s;
`ifdef SEQ_SUB32_OVF_EN
    logic           ovf_r,    ovf_nxt_s;
`endif

    // Chunk datapath signals
    logic [31:0]    off_s;
    logic [W-1:0]   a_sh_s;
    logic [W-1:0]   b_sh_s;
    logic [W-1:0]   mask_s;
    logic [CHUNK:0] sum_s;
    logic [W-1:0]   d_upd_s;

    // Select the active chunk and add it with the running carry
    always_comb begin
        off_s   = 32'(cnt_r) * 32'(CHUNK);
        a_sh_s  = a_r >> off_s;
        b_sh_s  = b_r >> off_s;
        sum_s   = {1'b0, a_sh_s[CHUNK-1:0]} + {1'b0, ~b_sh_s[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_r};
        mask_s  = W'({CHUNK{1'b1}}) << off_s;
        // Only the current chunk of d is replaced; the rest is kept.
        d_upd_s = (d_r & ~mask_s) | (W'(sum_s[CHUNK-1:0]) << off_s);
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        carry_nxt_s = carry_r;
        d_nxt_s     = d_r;
        bout_nxt_s  = bout_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
`ifdef SEQ_SUB32_OVF_EN
        ovf_nxt_s   = ovf_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new start just like IDLE, for back-to-back use.
                if (start) begin
                    state_nxt_s = ST_RUN;
                    a_nxt_s     = a;
                    b_nxt_s     = b;
                    carry_nxt_s = ~bin;
                    cnt_nxt_s   = {CW{1'b0}};
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_RUN: begin
                d_nxt_s     = d_upd_s;
                carry_nxt_s = sum_s[CHUNK];
                if (cnt_r == LAST) begin
                    state_nxt_s = ST_DONE;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                    bout_nxt_s  = ~sum_s[CHUNK];
`ifdef SEQ_SUB32_OVF_EN
                    ovf_nxt_s   = (a_r[W-1] != b_r[W-1]) && (d_upd_s[W-1] != a_r[W-1]);
`endif
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CW{1'b0}};
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            carry_r <= 1'b0;
            d_r     <= {W{1'b0}};
            bout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SEQ_SUB32_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            cnt_r   <= cnt_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            carry_r <= carry_nxt_s;
            d_r     <= d_nxt_s;
            bout_r  <= bout_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
`ifdef SEQ_SUB32_OVF_EN
            ovf_r   <= ovf_nxt_s;
`endif
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign d    = d_r;
    assign bout = bout_r;
`ifdef SEQ_SUB32_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_seq_sub32.sv
// ---------------------------------------------------------------------------
// tb_seq_sub32 : self-checking bench for seq_sub32
// Directed operands plus random ones against an arithmetic reference model;
// also handshake timing, start-while-busy, back-to-back and mid-run reset.
// ---------------------------------------------------------------------------
module tb_seq_sub32;

    localparam int W     = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = W / CHUNK;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SEQ_SUB32_OVF_EN
    logic         ovf;
`endif

    int total_cnt = 0;
    int bad_cnt   = 0;

    seq_sub32 #(.W(W), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
`ifdef SEQ_SUB32_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned values.
    function automatic logic [W-1:0] ref_d(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint unsigned r;
        r = longint'(x) + 64'h1_0000_0000 - longint'(y) - longint'(c);
        return r[W-1:0];
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return longint'(x) < (longint'(y) + longint'(c));
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] r);
        return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // One full operation: latency, busy length, result, done pulse width.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input string tag);
        int edges;
        int busy_cyc;
        logic [W-1:0] exp_d;
        exp_d = ref_d(ta, tb, tc);
        @(negedge clk);
        a = ta; b = tb; bin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // operands may change freely once accepted
        a = $urandom; b = $urandom; bin = 1'($urandom_range(1));
        edges = 1;
        busy_cyc = 0;
        while (!done && edges < NCH + 10) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_lat"}, 64'(edges), 64'(NCH + 1));
        check({tag, "_busycyc"}, 64'(busy_cyc), 64'(NCH));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy0"}, 64'(busy), 64'd0);
        check({tag, "_d"}, 64'(d), 64'(exp_d));
        check({tag, "_bout"}, 64'(bout), 64'(ref_bout(ta, tb, tc)));
`ifdef SEQ_SUB32_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(ta, tb, exp_d)));
`endif
        @(posedge clk); #1;
        check({tag, "_donepulse"}, 64'(done), 64'd0);
        check({tag, "_dhold"}, 64'(d), 64'(exp_d));
    endtask

    initial begin
        logic [W-1:0] ra, rb, d1, d2;
        logic         rc;
        int           ndone;
        int           stray;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_d", 64'(d), 64'd0);
        check("rst_bout", 64'(bout), 64'd0);
`ifdef SEQ_SUB32_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(32'd2000000014, 32'd1000000007, 1'b0, "dir_basic");
        run_op(32'd0, 32'd1, 1'b0, "dir_0m1");
        run_op(32'd5, 32'd5, 1'b1, "dir_bin");
        run_op(32'h12345678, 32'h0FEDCBA9, 1'b0, "dir_pat");
        run_op(32'h80000000, 32'd1, 1'b0, "dir_ovf1");
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, "dir_ovf2");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "dir_allone");
        run_op(32'h000000FF, 32'h00000001, 1'b0, "dir_chunkb");

        // Random cases
        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
            if (i % 6 == 0) rb = ra;
            run_op(ra, rb, rc, $sformatf("rnd%0d", i));
        end

        // start held high through RUN with changing operands: second op is
        // taken in the DONE cycle, done pulses once per op.
        ra = $urandom; rb = $urandom;
        d1 = ref_d(ra, rb, 1'b0);
        @(negedge clk);
        a = ra; b = rb; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        ra = $urandom; rb = $urandom; rc = 1'b1;
        a = ra; b = rb; bin = rc;
        d2 = ref_d(ra, rb, rc);
        ndone = 0;
        for (int i = 1; i <= 2 * NCH + 4; i++) begin
            @(posedge clk); #1;
            if (i == NCH + 1) begin
                start = 1'b0;
                a = $urandom; b = $urandom;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check("b2b_edge1", 64'(i), 64'(NCH));
                    check("b2b_d1", 64'(d), 64'(d1));
                end else begin
                    check("b2b_edge2", 64'(i), 64'(2 * NCH + 1));
                    check("b2b_d2", 64'(d), 64'(d2));
                    check("b2b_bout2", 64'(bout), 64'(ref_bout(ra, rb, rc)));
                end
            end
        end
        check("b2b_ndone", 64'(ndone), 64'd2);

        // Reset two cycles into RUN
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'h00000000; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("mid_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_d", 64'(d), 64'd0);
        check("mid_bout", 64'(bout), 64'd0);
        check("mid_done", 64'(done), 64'd0);
`ifdef SEQ_SUB32_OVF_EN
        check("mid_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < NCH + 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        check("mid_nodone", 64'(stray), 64'd0);
        run_op(32'h0000_1000, 32'h0000_0001, 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
